// File: rtl/poly_fir_interpolator.sv
// poly_fir_interpolator
// Polyphase FIR interpolator with a single time-shared multiplier.
// Low-rate samples arrive on tick_reduced_i and go into a T-deep circular
// buffer. Each tick_i runs one T-cycle multiply-accumulate over phase p,
// followed by a round/saturate cycle that updates signal_o.
//
// Strobe semantics: tick_reduced_i and tick_i are single-cycle strobes with
// no back-pressure. A tick_i that arrives while a computation is running is
// dropped and sets the sticky overrun_o. A tick_reduced_i that arrives while
// busy is parked in a one-entry holding register and committed on the edge
// back into IDLE. Overwriting a full holding register also sets overrun_o.
module poly_fir_interpolator #(
    parameter int num_bits_input       = 24,
    parameter int num_bits_output      = 24,
    parameter int interpolation_factor = 4,
    parameter int taps_per_phase       = 8,
    parameter int coef_bits            = 18,
    parameter int coef_frac_bits       = 16,
    // Entry p*T+k sits at bits [(p*T+k)*coef_bits +: coef_bits].
    parameter logic [interpolation_factor*taps_per_phase*coef_bits-1:0] coefs =
        {interpolation_factor{{((taps_per_phase-1)*coef_bits){1'b0}},
                              coef_bits'(1 << coef_frac_bits)}}
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       tick_reduced_i,
    input  logic                       tick_i,
    input  logic [num_bits_input-1:0]  signal_i,
    output logic [num_bits_output-1:0] signal_o,
    output logic                       valid_o,
    output logic                       overrun_o
);

    localparam int PROD_W = num_bits_input + coef_bits;
    localparam int ACC_W  = PROD_W + $clog2(taps_per_phase) + 1;
    localparam int PTR_W  = (taps_per_phase > 1) ? $clog2(taps_per_phase) : 1;
    localparam int PH_W   = (interpolation_factor > 1) ? $clog2(interpolation_factor) : 1;

    // Rounding constant (0.5 LSB of the output) and output saturation limits,
    // all expressed at accumulator width plus one guard bit.
    localparam logic signed [ACC_W:0] ROUND_HALF = {{ACC_W{1'b0}}, 1'b1} << (coef_frac_bits - 1);
    localparam logic signed [ACC_W:0] OUT_MAX    = ({{ACC_W{1'b0}}, 1'b1} << (num_bits_output - 1)) - 1;
    localparam logic signed [ACC_W:0] OUT_MIN    = ~OUT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2
    } state_t;

    state_t                            state_q, state_d;

    logic signed [num_bits_input-1:0]  buf_q [taps_per_phase];
    logic signed [num_bits_input-1:0]  buf_d [taps_per_phase];
    logic [PTR_W-1:0]                  head_q, head_d;        // index of x[0]
    logic                              hold_valid_q, hold_valid_d;
    logic [num_bits_input-1:0]         hold_data_q, hold_data_d;
    logic [PH_W-1:0]                   phase_q, phase_d;      // phase for the next tick
    logic [PH_W-1:0]                   act_phase_q, act_phase_d; // phase being computed
    logic [PTR_W-1:0]                  k_q, k_d;
    logic signed [ACC_W-1:0]           acc_q, acc_d;
    logic [num_bits_output-1:0]        signal_q, signal_d;
    logic                              valid_q, valid_d;
    logic                              overrun_q, overrun_d;

    // Datapath temporaries
    logic [PTR_W-1:0]                  rd_idx;
    logic signed [num_bits_input-1:0]  x_sel;
    logic signed [coef_bits-1:0]       h_sel;
    logic signed [PROD_W-1:0]          prod;
    logic signed [ACC_W:0]             round_sum;
    logic signed [ACC_W:0]             shifted;
    logic [num_bits_output-1:0]        sat_val;
    logic                              wr_en;
    logic [num_bits_input-1:0]         wr_data;
    logic                              mac_last;

    assign mac_last = (k_q == PTR_W'(taps_per_phase - 1));

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> MAC on tick, MAC for T cycles, one ROUND cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (tick_i)   state_d = ST_MAC;
            ST_MAC:   if (mac_last) state_d = ST_ROUND;
            ST_ROUND: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Multiply operand selection: x[k] and h[p][k] for the current MAC step
    always_comb begin
        rd_idx = PTR_W'((int'(head_q) + taps_per_phase - int'(k_q)) % taps_per_phase);
        x_sel  = buf_q[rd_idx];
        h_sel  = $signed(coefs[(int'(act_phase_q) * taps_per_phase + int'(k_q)) * coef_bits +: coef_bits]);
        prod   = PROD_W'(x_sel) * PROD_W'(h_sel);
    end

    // Round half up, arithmetic shift, then clamp to the output range
    always_comb begin
        round_sum = $signed({acc_q[ACC_W-1], acc_q}) + ROUND_HALF;
        shifted   = round_sum >>> coef_frac_bits;
        if (shifted > OUT_MAX) begin
            sat_val = num_bits_output'(OUT_MAX);
        end else if (shifted < OUT_MIN) begin
            sat_val = num_bits_output'(OUT_MIN);
        end else begin
            sat_val = num_bits_output'(shifted);
        end
    end

    // Output/datapath logic: sample writes, holding register, MAC, round, overrun
    always_comb begin
        buf_d        = buf_q;
        head_d       = head_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        phase_d      = phase_q;
        act_phase_d  = act_phase_q;
        k_d          = k_q;
        acc_d        = acc_q;
        signal_d     = signal_q;
        valid_d      = 1'b0;
        overrun_d    = overrun_q;
        wr_en        = 1'b0;
        wr_data      = signal_i;

        // Incoming low-rate sample: straight into the buffer when idle,
        // otherwise parked until the computation finishes.
        if (tick_reduced_i) begin
            if (state_q == ST_IDLE) begin
                wr_en   = 1'b1;
                wr_data = signal_i;
                phase_d = '0;
            end else begin
                if (hold_valid_q) begin
                    overrun_d = 1'b1;
                end
                hold_valid_d = 1'b1;
                hold_data_d  = signal_i;
            end
        end

        // A high-rate request while busy is lost.
        if (tick_i && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick_i) begin
                    // A same-cycle sample write resets the phase to 0 first.
                    act_phase_d = tick_reduced_i ? '0 : phase_q;
                    k_d         = '0;
                    acc_d       = '0;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
                k_d   = mac_last ? '0 : k_q + 1'b1;
            end
            ST_ROUND: begin
                signal_d = sat_val;
                valid_d  = 1'b1;
                phase_d  = PH_W'((int'(act_phase_q) + 1) % interpolation_factor);
                // Commit any parked sample on the way back into IDLE so the
                // very next tick already sees it at phase 0.
                if (hold_valid_d) begin
                    wr_en        = 1'b1;
                    wr_data      = hold_data_d;
                    hold_valid_d = 1'b0;
                    phase_d      = '0;
                end
            end
            default: ;
        endcase

        if (wr_en) begin
            head_d         = PTR_W'((int'(head_q) + 1) % taps_per_phase);
            buf_d[head_d]  = wr_data;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < taps_per_phase; i++) begin
                buf_q[i] <= '0;
            end
            head_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            phase_q      <= '0;
            act_phase_q  <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            signal_q     <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            head_q       <= head_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            phase_q      <= phase_d;
            act_phase_q  <= act_phase_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            signal_q     <= signal_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign signal_o  = signal_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_poly_fir_interpolator.sv
// Directed bench for poly_fir_interpolator, L=4, T=2, frac=16.
// Phase kernels: h[0]={65536,0} (ZOH), h[1]={32768,32768} (linear midpoint),
// h[2]={32768,0} (halving, rounding), h[3]={131071,0} (near-2x, saturation).
module tb_poly_fir_interpolator;

    localparam int L = 4;
    localparam int T = 2;
    localparam logic [L*T*18-1:0] COEFS = {
        18'd0, 18'd131071,
        18'd0, 18'd32768,
        18'd32768, 18'd32768,
        18'd0, 18'd65536
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_reduced = 1'b0;
    logic        tick = 1'b0;
    logic [23:0] sig_in = '0;
    logic [23:0] sig_out;
    logic        valid;
    logic        ovr;

    int n_checks = 0;
    int n_fail   = 0;

    poly_fir_interpolator #(
        .num_bits_input       (24),
        .num_bits_output      (24),
        .interpolation_factor (L),
        .taps_per_phase       (T),
        .coef_bits            (18),
        .coef_frac_bits       (16),
        .coefs                (COEFS)
    ) dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .tick_reduced_i (tick_reduced),
        .tick_i         (tick),
        .signal_i       (sig_in),
        .signal_o       (sig_out),
        .valid_o        (valid),
        .overrun_o      (ovr)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // one clock cycle with the given strobes; returns 1 time unit after the edge
    task automatic step(input logic t, input logic r, input int d);
        tick         = t;
        tick_reduced = r;
        sig_in       = 24'(d);
        @(posedge clk);
        #1;
        tick         = 1'b0;
        tick_reduced = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_sample(input int d);
        step(1'b0, 1'b1, d);
    endtask

    // wait for valid_o; 'start' is the cycle index already reached since the tick
    task automatic wait_out(input string tag, input int exp, input int start);
        int  n;
        bit  seen;
        n    = start;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (valid) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 1);
        check({tag, "_lat"}, n, T + 2);
        check({tag, "_val"}, $signed(sig_out), exp);
    endtask

    task automatic tick_out(input string tag, input int exp);
        step(1'b1, 1'b0, 0);
        wait_out(tag, exp, 1);
    endtask

    task automatic count_valids(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (valid) cnt++;
        end
    endtask

    initial begin
        int cnt;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_sig", $signed(sig_out), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_ovr", 32'(ovr), 0);
        rst = 1'b0;
        idle(2);

        // empty buffer, phase 0
        tick_out("zero_buf", 0);

        // linear kernel: 1000 then 3000
        send_sample(1000);
        tick_out("lin_a_p0", 1000);
        idle(6);
        tick_out("lin_a_p1", 500);
        send_sample(3000);
        tick_out("lin_b_p0", 3000);
        tick_out("lin_b_p1", 2000);
        tick_out("half_p2", 1500);
        tick_out("sat_p3_small", 6000);
        tick_out("wrap_p0", 3000);

        // rounding
        send_sample(3);
        tick_out("rnd_pos_p0", 3);
        tick_out("rnd_pos_p1", 1502);
        tick_out("rnd_pos_p2", 2);
        send_sample(-3);
        tick_out("rnd_neg_p0", -3);
        tick_out("rnd_neg_p1", 0);
        tick_out("rnd_neg_p2", -1);

        // saturation
        send_sample(8388607);
        tick_out("max_p0", 8388607);
        tick_out("max_p1", 4194302);
        tick_out("max_p2", 4194304);
        tick_out("max_p3", 8388607);
        send_sample(-8388608);
        tick_out("min_p0", -8388608);
        tick_out("min_p1", 0);
        tick_out("min_p2", -4194304);
        tick_out("min_p3", -8388608);

        // simultaneous sample and tick: computed on the new sample at phase 0
        step(1'b1, 1'b1, 500);
        wait_out("simul", 500, 1);

        // sample arriving during MAC is deferred; this phase-1 result uses old data
        step(1'b1, 1'b0, 0);
        send_sample(700);
        wait_out("defer_cur", -4194054, 2);
        // tick in the valid cycle is accepted and sees the deferred sample
        tick_out("defer_new", 700);
        tick_out("back2back", 600);
        check("ovr_clean", 32'(ovr), 0);

        // dropped tick
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        wait_out("drop_first", 350, 2);
        count_valids(10, cnt);
        check("drop_no_extra", cnt, 0);
        check("ovr_set", 32'(ovr), 1);
        tick_out("after_drop", 1400);
        check("ovr_sticky", 32'(ovr), 1);

        // asynchronous reset mid-MAC
        step(1'b1, 1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("amid_sig", $signed(sig_out), 0);
        check("amid_valid", 32'(valid), 0);
        check("amid_ovr", 32'(ovr), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_valids(8, cnt);
        check("amid_discard", cnt, 0);
        tick_out("amid_first", 0);
        check("amid_ovr_after", 32'(ovr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/poly_fir_interpolator.md
# poly_fir_interpolator

Time-multiplexed polyphase FIR interpolator. It takes low-rate samples on `tick_reduced_i` and produces one filtered high-rate sample per `tick_i`, using one multiplier. It sits in the output chain as the rate-raising counterpart of the FSM-based decimating FIR, between the low-rate processing and the DAC-side path.

## Interface
- `num_bits_input`, 24: signed input sample width.
- `num_bits_output`, 24: signed output sample width.
- `interpolation_factor` (L), 4: number of phases.
- `taps_per_phase` (T), 8: taps per phase.
- `coef_bits`, 18: signed coefficient width.
- `coef_frac_bits`, 16: coefficient fractional bits (1.0 = 65536).
- `coefs`: packed array of L*T coefficients. Entry p*T+k is h[p][k]. Default is a ZOH kernel: h[p][0]=65536, all others 0.

Ports:
- `clk_i` in 1: system clock.
- `reset_i` in 1: reset, asynchronous, active-high.
- `tick_reduced_i` in 1: low-rate strobe; `signal_i` is valid in this cycle.
- `tick_i` in 1: high-rate strobe; requests one output.
- `signal_i` in `num_bits_input`: signed low-rate sample.
- `signal_o` out `num_bits_output`: signed filtered sample, held between updates.
- `valid_o` out 1: one-cycle pulse when `signal_o` updates.
- `overrun_o` out 1: sticky flag, set when a `tick_i` is dropped; cleared only by reset.

## Operation
- **Sample buffer:** circular buffer of T entries; x[0] is the newest sample.
- **Sample write (FSM in IDLE):** on `tick_reduced_i`, write `signal_i` as the new x[0] and set phase p=0.
- **Sample write (FSM busy):** on `tick_reduced_i`, hold `signal_i` in a one-entry holding register. On return to IDLE, commit it to the buffer and set p=0; this happens before any new start. A second `tick_reduced_i` while the holding register is full overwrites it and sets `overrun_o`.
- **FSM states:** IDLE, MAC, ROUND.
  - IDLE: on `tick_i`, latch p and go to MAC. A sample write in the same cycle completes first, so the computation uses the new sample at p=0.
  - MAC: T cycles, k=0..T-1, acc += h[p][k]*x[k]. The accumulator is cleared on entry. Then go to ROUND.
  - ROUND: compute y = (acc + 2^(coef_frac_bits-1)) >>> coef_frac_bits, an arithmetic shift (round half up). Saturate y to the `num_bits_output` signed range. Register the result to `signal_o`, pulse `valid_o`, set p=(p+1) mod L, go to IDLE.
- **Dropped ticks:** `tick_i` outside IDLE is ignored and sets `overrun_o`.
- **Widths:**
  - Product: `num_bits_input`+`coef_bits`.
  - Accumulator: `num_bits_input`+`coef_bits`+clog2(T)+1. The accumulator never wraps.
- **More than L ticks per sample:** p wraps mod L.
- **Reset (any time, including mid-MAC):**
  - Buffer, holding register, `signal_o` and accumulator are 0.
  - `valid_o`=0, `overrun_o`=0, p=0, state IDLE.
  - A computation in progress is discarded with no `valid_o`.

## Timing
- **Latency:** `tick_i` sampled high in cycle 0 (IDLE) gives MAC in cycles 1..T, ROUND in cycle T+1, and `signal_o` updated with `valid_o`=1 in cycle T+2.
- **Tick spacing:** FSM is back in IDLE in cycle T+2, so the minimum `tick_i` spacing is T+2 cycles. A tick arriving in cycle T+2 is accepted.
- **Deferred sample:** committed on the edge into IDLE, so it is visible to a `tick_i` accepted in cycle T+2.
- **Output hold:** `signal_o` is stable between `valid_o` pulses.
- **No input handshake:** inputs are single-cycle strobes.

## Test plan
All scenarios use L=2, T=2, frac=16 unless stated.
- **Reset:**
  - Assert `reset_i` asynchronously mid-MAC -> `signal_o`=0, `valid_o`=0, `overrun_o`=0 immediately.
  - After release, the first output with zero buffer is 0.
- **ZOH kernel latency:**
  - Sample 1000, then `tick_i` twice spaced 10 cycles -> outputs 1000, 1000.
  - Each `valid_o` arrives exactly 4 cycles after its tick.
- **Linear kernel** (h[0]={65536,0}, h[1]={32768,32768}):
  - Samples 1000 then 3000, two ticks each -> outputs 1000, 500, 3000, 2000.
- **Rounding and saturation:**
  - h[p][0]=32768: input 3 -> 2; input -3 -> -1.
  - h[p][0]=131071: input 8388607 -> 8388607; input -8388608 -> -8388608 (saturated).
- **Overrun:**
  - `tick_i` on consecutive cycles -> one `valid_o` only; `overrun_o`=1 and stays 1 until reset.
  - `tick_i` exactly 4 cycles apart -> two outputs, `overrun_o`=0.
- **Simultaneous and deferred samples:**
  - `tick_reduced_i`(500) and `tick_i` in the same cycle (ZOH) -> output 500.
  - `tick_reduced_i`(700) during MAC -> next tick outputs 700 with p=0; `overrun_o` stays 0.
